// File: rtl/pipe_rca_adder.sv
// pipe_rca_adder: pipelined ripple-carry adder, WIDTH bits split into STAGES
// carry-chained segments with one register boundary per segment and a
// valid/ready handshake on both sides.
// Optional feature: define PIPE_ADDER_SAT_EN for unsigned saturation of sum
// when the final carry is set (co still reports the true carry).
module pipe_rca_adder #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co
);

   localparam int unsigned SEG   = WIDTH / STAGES;
   localparam int unsigned SEG_W = SEG + 1;

   // Per-stage registers: operands still to be added (skew), partial sum
   // (deskew), carry into the next segment and the beat's valid bit.
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] s_q [STAGES];
   logic             c_q [STAGES];
   logic             v_q [STAGES];

   logic advance;

   // Whole pipeline moves together; it freezes only when the output is held.
   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;
   assign out_valid = v_q[STAGES-1];
   assign sum       = s_q[STAGES-1];
   assign co        = c_q[STAGES-1];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] a_src;
      logic [WIDTH-1:0] b_src;
      logic [WIDTH-1:0] s_src;
      logic             c_src;
      logic             v_src;
      logic [SEG:0]     seg_sum;
      logic [WIDTH-1:0] s_nxt;

      if (k == 0) begin : g_first
         // Bubbles load zeros so no X can reach sum while out_valid is low.
         assign a_src = in_valid ? a : '0;
         assign b_src = in_valid ? b : '0;
         assign s_src = '0;
         assign c_src = in_valid & ci;
         assign v_src = in_valid;
      end else begin : g_next
         assign a_src = a_q[k-1];
         assign b_src = b_q[k-1];
         assign s_src = s_q[k-1];
         assign c_src = c_q[k-1];
         assign v_src = v_q[k-1];
      end

      // Segment k adder, carry taken from the previous stage's register.
      assign seg_sum = {1'b0, a_src[k*SEG +: SEG]} + {1'b0, b_src[k*SEG +: SEG]}
                     + SEG_W'(c_src);

      // Merge this segment's result into the partial sum.
      always_comb begin
         s_nxt                = s_src;
         s_nxt[k*SEG +: SEG]  = seg_sum[SEG-1:0];
`ifdef PIPE_ADDER_SAT_EN
         if ((k == STAGES - 1) && seg_sum[SEG]) begin
            s_nxt = '1;
         end
`endif
      end

      // Stage register: cleared asynchronously, held while stalled.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
            v_q[k] <= 1'b0;
         end else if (advance) begin
            a_q[k] <= a_src;
            b_q[k] <= b_src;
            s_q[k] <= s_nxt;
            c_q[k] <= seg_sum[SEG];
            v_q[k] <= v_src;
         end
      end
   end

endmodule
